// File: rtl/ahb_sram.sv
// rtl/ahb_sram.sv - AHB-lite slave SRAM with byte lanes, wait states and two-cycle error responses
//
// Ports:
//   hclk, hreset        clock (rising edge) and asynchronous active-high reset
//   hsel, htrans, haddr, hwrite, hsize, hready
//                       address-phase qualifiers; a transfer is accepted on
//                       hsel & hready & htrans[1]
//   hburst, hprot, hmastlock
//                       accepted and ignored; every beat is an independent transfer
//   hwdata              write data, sampled on the cycle that ends the data phase
//   hrdata              full memory word during the final read data-phase cycle, else 0
//   hresp, hreadyout    response and slave ready, decoded from the FSM state only
module ahb_sram #(
    parameter int          ADDR  = 32,
    parameter int          DATA  = 32,
    parameter int          DEPTH = 1024,
    parameter int unsigned BASE  = 0,
    parameter int          WAIT  = 0
) (
    input  logic            hclk,
    input  logic            hreset,
    input  logic            hsel,
    input  logic [1:0]      htrans,
    input  logic [2:0]      hburst,
    input  logic [2:0]      hsize,
    input  logic [3:0]      hprot,
    input  logic            hmastlock,
    input  logic [ADDR-1:0] haddr,
    input  logic            hwrite,
    input  logic [DATA-1:0] hwdata,
    input  logic            hready,
    output logic [DATA-1:0] hrdata,
    output logic            hresp,
    output logic            hreadyout
);
    localparam int              BYTES     = DATA / 8;
    localparam int              LB        = $clog2(BYTES);
    localparam int              IW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR-1:0] MEM_BYTES = ADDR'(DEPTH * BYTES);
    localparam logic [2:0]      WAIT_LOAD = (WAIT > 0) ? 3'(WAIT - 1) : 3'd0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAITST,
        S_DATA,
        S_ERR1,
        S_ERR2
    } state_t;

    state_t          state_q, state_d;
    logic [2:0]      cnt_q, cnt_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [LB-1:0]   lane_q, lane_d;
    logic [2:0]      size_q, size_d;
    logic            write_q, write_d;

    logic [DATA-1:0] mem [DEPTH];

    logic [ADDR-1:0] offset;
    logic            accept;
    logic            bad;
    logic [BYTES-1:0] lane_mask;
    logic [DATA-1:0] rd_word;
    logic [DATA-1:0] wr_word;
    logic            commit;

    logic            unused_inputs;
    assign unused_inputs = ^{hburst, hprot, hmastlock, htrans[0]};

    // Offset relative to BASE wraps unsigned, so addresses below BASE land
    // far out of range and are rejected by the same compare.
    assign offset = haddr - ADDR'(BASE);
    assign accept = hsel && hready && htrans[1];
    assign bad    = (offset >= MEM_BYTES)
                 || (int'(hsize) > LB)
                 || ((haddr & ((ADDR'(1) << hsize) - ADDR'(1))) != '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        lane_d  = lane_q;
        size_d  = size_q;
        write_d = write_q;
        case (state_q)
            S_WAITST: begin
                if (cnt_q == 3'd0) begin
                    state_d = S_DATA;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            S_ERR1: state_d = S_ERR2;
            default: begin
                // IDLE, DATA and ERR2 all end with hreadyout=1, so each can
                // take a new address phase.
                state_d = S_IDLE;
                if (accept) begin
                    idx_d   = offset[LB +: IW];
                    lane_d  = haddr[LB-1:0];
                    size_d  = hsize;
                    write_d = hwrite;
                    if (bad) begin
                        state_d = S_ERR1;
                    end else if (WAIT > 0) begin
                        state_d = S_WAITST;
                        cnt_d   = WAIT_LOAD;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            lane_q  <= '0;
            size_q  <= '0;
            write_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            lane_q  <= lane_d;
            size_q  <= size_d;
            write_q <= write_d;
        end
    end

    always_comb begin
        lane_mask = '0;
        for (int b = 0; b < BYTES; b++) begin
            lane_mask[b] = (b >= int'(lane_q)) && (b < int'(lane_q) + (1 << size_q));
        end
    end

    assign rd_word = mem[idx_q];

    always_comb begin
        wr_word = rd_word;
        for (int b = 0; b < BYTES; b++) begin
            if (lane_mask[b]) begin
                wr_word[8*b +: 8] = hwdata[8*b +: 8];
            end
        end
    end

    // The write lands on the edge ending the data phase, which is also the
    // edge that starts a following read's data phase, so a back-to-back read
    // of the same word already sees the merged data.
    assign commit = (state_q == S_DATA) && write_q;

    always_ff @(posedge hclk) begin
        if (commit) begin
            mem[idx_q] <= wr_word;
        end
    end

    assign hreadyout = !((state_q == S_WAITST) || (state_q == S_ERR1));
    assign hresp     = (state_q == S_ERR1) || (state_q == S_ERR2);
    assign hrdata    = ((state_q == S_DATA) && !write_q) ? rd_word : '0;

endmodule

// File: tb/tb_ahb_sram.sv
// tb/tb_ahb_sram.sv - scoreboard bench for ahb_sram with WAIT=0 and WAIT=3 instances
module tb_ahb_sram;
    localparam int          DEPTH = 256;
    localparam logic [31:0] BASE0 = 32'h0000_1000;
    localparam logic [31:0] BASE1 = 32'h0000_2000;
    localparam int          WAIT0 = 0;
    localparam int          WAIT1 = 3;

    typedef struct {
        logic        sel;
        logic [1:0]  trans;
        logic [31:0] addr;
        logic [2:0]  size;
        logic        wr;
        logic [31:0] wdata;
    } xfer_t;

    typedef struct {
        logic        err;
        logic        rd;
        logic [31:0] data;
    } exp_t;

    logic        hclk = 1'b0;
    logic        hreset = 1'b1;
    logic        hsel_b = 1'b0;
    logic [1:0]  htrans_b = 2'b00;
    logic [2:0]  hburst_b = 3'd0;
    logic [2:0]  hsize_b = 3'd0;
    logic [3:0]  hprot_b = 4'd0;
    logic        hmastlock_b = 1'b0;
    logic [31:0] haddr_b = 32'h0;
    logic        hwrite_b = 1'b0;
    logic [31:0] hwdata_b = 32'h0;

    logic        hsel0, hsel1;
    logic [31:0] hrdata0, hrdata1;
    logic        hresp0, hresp1, hreadyout0, hreadyout1;
    logic [31:0] m_rdata;
    logic        m_resp, m_ready;

    int          cur = 0;
    bit          mon_en = 1'b0;
    int          checks = 0;
    int          errors = 0;

    xfer_t       txq[$];
    exp_t        expq[$];
    logic [7:0]  mdl [2][DEPTH*4];

    assign hsel0   = hsel_b && (cur == 0);
    assign hsel1   = hsel_b && (cur == 1);
    assign m_rdata = (cur == 0) ? hrdata0 : hrdata1;
    assign m_resp  = (cur == 0) ? hresp0 : hresp1;
    assign m_ready = (cur == 0) ? hreadyout0 : hreadyout1;

    always #5 hclk = ~hclk;

    ahb_sram #(.ADDR(32), .DATA(32), .DEPTH(DEPTH), .BASE(BASE0), .WAIT(WAIT0)) u_dut0 (
        .hclk(hclk), .hreset(hreset), .hsel(hsel0), .htrans(htrans_b), .hburst(hburst_b),
        .hsize(hsize_b), .hprot(hprot_b), .hmastlock(hmastlock_b), .haddr(haddr_b),
        .hwrite(hwrite_b), .hwdata(hwdata_b), .hready(hreadyout0),
        .hrdata(hrdata0), .hresp(hresp0), .hreadyout(hreadyout0)
    );

    ahb_sram #(.ADDR(32), .DATA(32), .DEPTH(DEPTH), .BASE(BASE1), .WAIT(WAIT1)) u_dut1 (
        .hclk(hclk), .hreset(hreset), .hsel(hsel1), .htrans(htrans_b), .hburst(hburst_b),
        .hsize(hsize_b), .hprot(hprot_b), .hmastlock(hmastlock_b), .haddr(haddr_b),
        .hwrite(hwrite_b), .hwdata(hwdata_b), .hready(hreadyout1),
        .hrdata(hrdata1), .hresp(hresp1), .hreadyout(hreadyout1)
    );

    function automatic logic [31:0] base_of(input int i);
        return (i == 0) ? BASE0 : BASE1;
    endfunction

    function automatic int wait_of(input int i);
        return (i == 0) ? WAIT0 : WAIT1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Reference model: memory as a flat byte array, transfers applied in issue order.
    task automatic issue(input logic sel, input logic [1:0] tr, input logic [31:0] a,
                         input logic [2:0] sz, input logic wr, input logic [31:0] wd);
        xfer_t       x;
        exp_t        e;
        logic [31:0] off;
        int          n, o, w;
        x.sel = sel; x.trans = tr; x.addr = a; x.size = sz; x.wr = wr; x.wdata = wd;
        txq.push_back(x);
        if (sel && tr[1]) begin
            off    = a - base_of(cur);
            n      = 1 << sz;
            e.err  = (off >= 32'(DEPTH * 4)) || (sz > 3'd2) || ((a & 32'(n - 1)) != 0);
            e.rd   = !wr;
            e.data = 32'h0;
            if (!e.err) begin
                o = int'(off);
                w = o & ~3;
                if (wr) begin
                    for (int k = 0; k < n; k++) mdl[cur][o+k] = wd[8*((o+k)%4) +: 8];
                end else begin
                    e.data = {mdl[cur][w+3], mdl[cur][w+2], mdl[cur][w+1], mdl[cur][w]};
                end
            end
            expq.push_back(e);
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((txq.size() > 0 || expq.size() > 0) && n < 2000) begin
            @(negedge hclk);
            n++;
        end
        repeat (8) @(negedge hclk);
        chk("drain_bound", 32'(n < 2000), 32'd1);
        if (n >= 2000) begin
            txq.delete();
            expq.delete();
        end
    endtask

    // Master: moves address phase to data phase on every edge with hready high.
    initial begin : driver
        xfer_t ap, dp, idle_x;
        logic  rdy;
        idle_x.sel = 1'b0; idle_x.trans = 2'b00; idle_x.addr = 32'h0;
        idle_x.size = 3'd0; idle_x.wr = 1'b0; idle_x.wdata = 32'h0;
        ap = idle_x;
        dp = idle_x;
        forever begin
            @(negedge hclk);
            rdy = m_ready;
            @(posedge hclk);
            if (hreset) begin
                ap = idle_x;
                dp = idle_x;
            end else if (rdy) begin
                dp = ap;
                if (txq.size() > 0) ap = txq.pop_front();
                else ap = idle_x;
            end
            #1;
            hsel_b      = ap.sel;
            htrans_b    = ap.trans;
            haddr_b     = ap.addr;
            hsize_b     = ap.size;
            hwrite_b    = ap.wr;
            hwdata_b    = dp.wdata;
            hburst_b    = 3'($urandom);
            hprot_b     = 4'($urandom);
            hmastlock_b = 1'($urandom);
        end
    end

    // Monitor: follows data phases on the bus and pops one expectation per transfer.
    initial begin : monitor
        bit   in_dp = 1'b0;
        int   low = 0;
        exp_t e;
        logic acc;
        e.err = 1'b0; e.rd = 1'b0; e.data = 32'h0;
        forever begin
            @(negedge hclk);
            if (!mon_en) begin
                in_dp = 1'b0;
                low   = 0;
            end else begin
                acc = m_ready && hsel_b && htrans_b[1];
                if (in_dp) begin
                    if (!m_ready) begin
                        low++;
                        chk("wait_hresp", 32'(m_resp), 32'(e.err));
                        chk("wait_hrdata", m_rdata, 32'h0);
                        if (low > 8) begin
                            chk("ready_bound", 32'(low), 32'd8);
                            in_dp = 1'b0;
                        end
                    end else begin
                        chk("low_cycles", 32'(low), e.err ? 32'd1 : 32'(wait_of(cur)));
                        chk("final_hresp", 32'(m_resp), 32'(e.err));
                        chk("final_hrdata", m_rdata, (e.rd && !e.err) ? e.data : 32'h0);
                        in_dp = 1'b0;
                    end
                end else begin
                    chk("idle_ready", 32'(m_ready), 32'd1);
                    chk("idle_hresp", 32'(m_resp), 32'd0);
                    chk("idle_hrdata", m_rdata, 32'h0);
                end
                if (acc) begin
                    if (expq.size() == 0) begin
                        chk("unexpected_accept", 32'(expq.size()), 32'd1);
                    end else begin
                        e     = expq.pop_front();
                        in_dp = 1'b1;
                        low   = 0;
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        errors++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [31:0] b, a, off;
        logic [2:0]  sz;
        xfer_t       x;
        int          n;

        repeat (3) @(negedge hclk);
        chk("rst_ready0", 32'(hreadyout0), 32'd1);
        chk("rst_hresp0", 32'(hresp0), 32'd0);
        chk("rst_hrdata0", hrdata0, 32'h0);
        chk("rst_ready1", 32'(hreadyout1), 32'd1);
        chk("rst_hresp1", 32'(hresp1), 32'd0);
        chk("rst_hrdata1", hrdata1, 32'h0);
        hreset = 1'b0;
        @(negedge hclk);
        mon_en = 1'b1;

        for (int inst = 0; inst < 2; inst++) begin
            cur = inst;
            b   = base_of(inst);
            @(negedge hclk);
            for (int w = 0; w < 16; w++) issue(1'b1, 2'b10, b + 32'(4*w), 3'd2, 1'b1, $urandom);

            issue(1'b1, 2'b10, b + 32'h10, 3'd2, 1'b1, 32'hDEAD_BEEF);
            issue(1'b1, 2'b10, b + 32'h10, 3'd2, 1'b0, 32'h0);
            issue(1'b1, 2'b10, b + 32'h10, 3'd2, 1'b1, 32'h0000_0000);
            issue(1'b1, 2'b11, b + 32'h13, 3'd0, 1'b1, 32'hAB00_0000);
            issue(1'b1, 2'b10, b + 32'h10, 3'd1, 1'b1, 32'h0000_1234);
            issue(1'b1, 2'b10, b + 32'h10, 3'd2, 1'b0, 32'h0);

            issue(1'b1, 2'b10, b + 32'(DEPTH*4), 3'd2, 1'b1, 32'hFFFF_FFFF);
            issue(1'b1, 2'b10, b + 32'h2, 3'd2, 1'b1, 32'hFFFF_FFFF);
            issue(1'b1, 2'b10, b + 32'h0, 3'd3, 1'b1, 32'hFFFF_FFFF);
            issue(1'b1, 2'b10, b + 32'h5, 3'd1, 1'b1, 32'hFFFF_FFFF);
            issue(1'b1, 2'b10, b - 32'h4, 3'd2, 1'b1, 32'hFFFF_FFFF);
            issue(1'b1, 2'b10, b + 32'h0, 3'd2, 1'b0, 32'h0);
            issue(1'b1, 2'b10, b + 32'h4, 3'd2, 1'b0, 32'h0);

            issue(1'b1, 2'b00, b + 32'h8, 3'd2, 1'b1, 32'h1111_1111);
            issue(1'b1, 2'b01, b + 32'h8, 3'd2, 1'b1, 32'h2222_2222);
            issue(1'b0, 2'b10, b + 32'h8, 3'd2, 1'b1, 32'h3333_3333);
            issue(1'b0, 2'b11, b + 32'h8, 3'd2, 1'b1, 32'h4444_4444);
            issue(1'b1, 2'b10, b + 32'h8, 3'd2, 1'b0, 32'h0);

            for (int k = 0; k < 4; k++) issue(1'b1, 2'b10, b + 32'(4*k), 3'd2, 1'b0, 32'h0);

            repeat (150) begin
                sz  = ($urandom_range(0, 9) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
                off = 32'($urandom_range(0, 63));
                if ($urandom_range(0, 4) != 0) off = off & ~((32'd1 << sz) - 32'd1);
                a = ($urandom_range(0, 19) == 0) ? b + 32'(DEPTH*4) + off : b + off;
                issue(1'($urandom_range(0, 9) != 0), 2'($urandom_range(0, 3)), a, sz,
                      1'($urandom_range(0, 1)), $urandom);
            end
            drain();
        end

        // Reset in the middle of a WAIT=3 write: the write must be lost.
        mon_en = 1'b0;
        @(negedge hclk);
        x.sel = 1'b1; x.trans = 2'b10; x.addr = b + 32'h20; x.size = 3'd2;
        x.wr = 1'b1; x.wdata = 32'h55AA_55AA;
        txq.push_back(x);
        n = 0;
        while (hreadyout1 !== 1'b0 && n < 20) begin
            @(negedge hclk);
            n++;
        end
        chk("reach_waitst", 32'(n < 20), 32'd1);
        #2;
        hreset = 1'b1;
        #1;
        chk("async_rst_ready", 32'(hreadyout1), 32'd1);
        chk("async_rst_hresp", 32'(hresp1), 32'd0);
        chk("async_rst_hrdata", hrdata1, 32'h0);
        @(negedge hclk);
        @(negedge hclk);
        hreset = 1'b0;
        @(negedge hclk);
        mon_en = 1'b1;
        issue(1'b1, 2'b10, b + 32'h20, 3'd2, 1'b0, 32'h0);
        issue(1'b1, 2'b10, b + 32'h24, 3'd2, 1'b1, 32'hC0FF_EE00);
        issue(1'b1, 2'b10, b + 32'h24, 3'd2, 1'b0, 32'h0);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ahb_sram.md
# ahb_sram

Parametrised AHB-lite slave SRAM with configurable width, depth, base address and wait states. It replaces the empty memory slave stub as the default on-bus memory model behind the decoder. It performs real byte-lane reads and writes and inserts programmable wait states. It returns two-cycle ERROR responses for out-of-range, misaligned or oversized transfers.

## Interface
- ADDR, 32, haddr width
- DATA, 32, data bus width; 32 or 64 only
- DEPTH, 1024, number of DATA-wide words
- BASE, 0, byte base address; aligned to DEPTH*DATA/8
- WAIT, 0, wait states per OKAY data phase, 0..7

Ports:
- hclk  in  1  clock; all logic on rising edge
- hreset  in  1  reset; asynchronous, active-high
- hsel  in  1  slave select from decoder
- htrans  in  2  0 IDLE, 1 BUSY, 2 NONSEQ, 3 SEQ
- hburst  in  3  burst type; accepted, ignored
- hsize  in  3  transfer size, log2 bytes
- hprot  in  4  protection; accepted, ignored
- hmastlock  in  1  lock; accepted, ignored
- haddr  in  ADDR  byte address
- hwrite  in  1  1 write, 0 read
- hwdata  in  DATA  write data, valid in data phase
- hready  in  1  bus-wide ready (muxed)
- hrdata  out  DATA  read data
- hresp  out  1  0 OKAY, 1 ERROR
- hreadyout  out  1  slave ready

## Operation
- Address phase accepted when hsel & hready & htrans[1]; latch addr, hsize, hwrite. IDLE/BUSY or hsel=0: OKAY, zero wait, no access.
- Error if any holds: haddr-BASE >= DEPTH*DATA/8 (unsigned), hsize > log2(DATA/8), haddr not aligned to 2^hsize. Errored writes never modify memory.
- Word index = (haddr-BASE) >> log2(DATA/8); byte lanes = 2^hsize bytes starting at haddr[log2(DATA/8)-1:0], little-endian.
- FSM states:
  - IDLE: hreadyout=1, hresp=0.
  - WAITST: hreadyout=0, hresp=0; counter counts WAIT-1 down to 0, then DATA.
  - DATA: hreadyout=1, hresp=0; data phase completes.
  - ERR1: hreadyout=0, hresp=1; always goes to ERR2.
  - ERR2: hreadyout=1, hresp=1.
- From IDLE, DATA or ERR2, an accepted good transfer goes to WAITST if WAIT>0, else DATA. An accepted bad transfer goes to ERR1. Otherwise the FSM goes to IDLE.
- Write commits on the clock edge ending the data phase (hreadyout=1), using hwdata lanes selected by the latched size/address. Other lanes are unchanged.
- Read: hrdata = full word at the latched index during the final data-phase cycle (hreadyout=1), 0 in all other cycles. Unselected lanes carry memory contents.
- Read-after-write forwarding is mandatory. A read whose address phase coincides with a write data phase to the same word returns the merged new data.
- Data phase proceeds once started; hsel/htrans changes do not abort it.
- hburst ignored: each beat is an independent transfer; SEQ is treated as NONSEQ.
- Reset: hreadyout=1, hresp=0, hrdata=0, FSM IDLE, counter 0. Memory contents not reset. Reset mid-transfer discards any pending write.

## Timing
- WAIT=0: one transfer per cycle. Data phase is the cycle after the address phase. Back-to-back pipelined NONSEQ transfers sustain full throughput.
- WAIT=N: hreadyout low for exactly N cycles, then high for 1 cycle.
- Error: always exactly 2 cycles (ERR1, ERR2), independent of WAIT. Address phase presented during ERR1 is ignored (hready=0); the master may cancel to IDLE during ERR1.
- hrdata, hresp and hreadyout are registered or FSM-decoded; none depend combinationally on address-phase inputs.

## Test plan
- WAIT=0: write 0xDEADBEEF at BASE+0x10, then read 0x10 next cycle (pipelined) -> hrdata=0xDEADBEEF, hreadyout never low, forwarding exercised.
- Byte/halfword lanes: word 0x00000000, byte write 0xAB at +0x13, halfword 0x1234 at +0x10 -> word read returns 0xAB001234.
- WAIT=3: single read -> hreadyout low exactly 3 cycles then high 1 cycle with data; 4 back-to-back reads take 16 data cycles.
- Errors: address BASE+DEPTH*4, then hsize=2 at +0x2, then hsize=3 on DATA=32 -> each gives hresp=1 for 2 cycles with hreadyout 0 then 1; memory unchanged on re-read.
- IDLE/BUSY with hsel=1, and NONSEQ with hsel=0 -> OKAY, hreadyout=1, no memory change.
- Assert hreset during WAITST of a write of 0x55AA55AA -> outputs return to reset values immediately; word retains its old value; next transfer completes normally.
